// File: rtl/shift_reg_pkg.sv
// Shared operation encodings for the universal shift register and its bench.
package shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_CLR  = 3'd6;
  localparam logic [2:0] MODE_INV  = 3'd7;

  typedef logic [2:0] mode_t;

endpackage

// File: rtl/dff_en_cell.sv
// One-bit storage cell: synchronous active-low reset to a fixed value, load enable,
// true and complement outputs.
module dff_en_cell #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q,
  output logic qbar
);

  logic state_q;

  // Reset wins over enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RESET_VAL;
    end else if (en) begin
      state_q <= d;
    end
  end

  assign q    = state_q;
  assign qbar = ~state_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, load, shift, rotate, clear and invert, one
// operation per enabled clock edge, with serial outputs for chaining.
module univ_shift_reg
  import shift_reg_pkg::*;
#(
  parameter int unsigned     WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout_l,
  output logic             sout_r
);

  logic [WIDTH-1:0] q_next;

  // Shift forms written so that WIDTH=1 degenerates correctly without slicing q.
  always_comb begin
    q_next = q;
    case (mode)
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = (q << 1) | WIDTH'(sin_r);
      MODE_SHR:  q_next = (q >> 1) | (WIDTH'(sin_l) << (WIDTH - 1));
      MODE_ROL:  q_next = (q << 1) | WIDTH'(q[WIDTH-1]);
      MODE_ROR:  q_next = (q >> 1) | (WIDTH'(q[0]) << (WIDTH - 1));
      MODE_CLR:  q_next = '0;
      MODE_INV:  q_next = ~q;
      default:   q_next = q;
    endcase
  end

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    dff_en_cell #(
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .d    (q_next[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench: two chained 8-bit instances plus a 1-bit instance, checked every cycle
// against an arithmetic reference model, with literal checkpoints.
module tb_univ_shift_reg;
  import shift_reg_pkg::*;

  localparam logic [7:0] RA = 8'hA5;
  localparam logic [7:0] RB = 8'h3D;
  localparam logic       RC = 1'b1;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [2:0] mode;
  logic [7:0] da, db;
  logic       sr_a, sl_b, dc, sl_c, sr_c;

  logic [7:0] qa, qbar_a, qb, qbar_b;
  logic       sout_l_a, sout_r_a, sout_l_b, sout_r_b;
  logic       qc, qbar_c, sout_l_c, sout_r_c;

  logic [63:0] ma, mb, mc;
  logic        chk_en = 1'b0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(RA)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(da), .sin_r(sr_a), .sin_l(sout_r_b),
    .q(qa), .qbar(qbar_a), .sout_l(sout_l_a), .sout_r(sout_r_a)
  );

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(RB)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(db), .sin_r(sout_l_a), .sin_l(sl_b),
    .q(qb), .qbar(qbar_b), .sout_l(sout_l_b), .sout_r(sout_r_b)
  );

  univ_shift_reg #(.WIDTH(1), .RESET_VAL(RC)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(dc), .sin_r(sr_c), .sin_l(sl_c),
    .q(qc), .qbar(qbar_c), .sout_l(sout_l_c), .sout_r(sout_r_c)
  );

  // Reference: register value as an unsigned integer of w bits.
  function automatic logic [63:0] model_next(input logic [63:0] cur, input int w,
                                             input logic [2:0] m, input logic [63:0] din,
                                             input logic sl, input logic sr);
    logic [63:0] mask;
    logic [63:0] msb;
    logic [63:0] lsb;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    msb  = (cur >> (w - 1)) & 64'd1;
    lsb  = cur & 64'd1;
    case (m)
      MODE_LOAD: return din & mask;
      MODE_SHL:  return ((cur * 2) + 64'(sr)) & mask;
      MODE_SHR:  return (cur / 2) + (64'(sl) << (w - 1));
      MODE_ROL:  return ((cur * 2) + msb) & mask;
      MODE_ROR:  return (cur / 2) + (lsb << (w - 1));
      MODE_CLR:  return 64'd0;
      MODE_INV:  return mask - cur;
      default:   return cur;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      ma <= 64'(RA);
      mb <= 64'(RB);
      mc <= 64'(RC);
    end else if (en) begin
      ma <= model_next(ma, 8, mode, 64'(da), mb[0], sr_a);
      mb <= model_next(mb, 8, mode, 64'(db), sl_b, ma[7]);
      mc <= model_next(mc, 1, mode, 64'(dc), sl_c, sr_c);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string name, input logic [63:0] dut, input logic [63:0] mdl,
                     input logic [63:0] exp);
    check({name, "_model"}, mdl, exp);
    check({name, "_dut"}, dut, exp);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("q_a", 64'(qa), ma);
      check("qbar_a", 64'(qbar_a), ~ma & 64'hFF);
      check("sout_l_a", 64'(sout_l_a), (ma >> 7) & 64'd1);
      check("sout_r_a", 64'(sout_r_a), ma & 64'd1);
      check("q_b", 64'(qb), mb);
      check("qbar_b", 64'(qbar_b), ~mb & 64'hFF);
      check("sout_l_b", 64'(sout_l_b), (mb >> 7) & 64'd1);
      check("sout_r_b", 64'(sout_r_b), mb & 64'd1);
      check("q_c", 64'(qc), mc);
      check("qbar_c", 64'(qbar_c), ~mc & 64'd1);
      check("sout_l_c", 64'(sout_l_c), mc);
      check("sout_r_c", 64'(sout_r_c), mc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic e, input logic [2:0] m);
    en   = e;
    mode = m;
    tick();
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; mode = MODE_HOLD; da = '0; db = '0;
    sr_a = 1'b0; sl_b = 1'b0; dc = 1'b0; sl_c = 1'b0; sr_c = 1'b0;

    tick();
    lit("rst_q", 64'(qa), ma, 64'hA5);
    lit("rst_qbar", 64'(qbar_a), ~ma & 64'hFF, 64'h5A);
    check("rst_sout_l", 64'(sout_l_a), 64'd1);
    check("rst_sout_r", 64'(sout_r_a), 64'd1);
    check("rst_q_c", 64'(qc), 64'd1);
    chk_en = 1'b1;
    rst    = 1'b1;

    da = 8'h3C; db = 8'h00;
    op(1'b1, MODE_LOAD);
    lit("load_3c", 64'(qa), ma, 64'h3C);
    sr_a = 1'b1;
    op(1'b1, MODE_SHL);
    lit("shl_1", 64'(qa), ma, 64'h79);
    op(1'b1, MODE_SHL);
    lit("shl_2", 64'(qa), ma, 64'hF3);
    op(1'b1, MODE_SHL);
    lit("shl_3", 64'(qa), ma, 64'hE7);
    lit("shl_3_b", 64'(qb), mb, 64'h01);

    da = 8'h80; db = 8'h00; sr_a = 1'b0;
    op(1'b1, MODE_LOAD);
    op(1'b1, MODE_SHL);
    lit("chain_a", 64'(qa), ma, 64'h00);
    lit("chain_b", 64'(qb), mb, 64'h01);

    da = 8'h81;
    op(1'b1, MODE_LOAD);
    op(1'b1, MODE_ROR);
    lit("ror", 64'(qa), ma, 64'hC0);
    op(1'b1, MODE_ROL);
    lit("rol_1", 64'(qa), ma, 64'h81);
    op(1'b1, MODE_ROL);
    lit("rol_2", 64'(qa), ma, 64'h03);

    da = 8'h0F;
    op(1'b1, MODE_LOAD);
    for (int m = 1; m <= 7; m++) begin
      da   = 8'($urandom);
      db   = 8'($urandom);
      sr_a = 1'($urandom);
      sl_b = 1'($urandom);
      op(1'b0, 3'(m));
      lit("en0_hold", 64'(qa), ma, 64'h0F);
    end
    op(1'b1, MODE_INV);
    lit("inv", 64'(qa), ma, 64'hF0);
    op(1'b1, MODE_CLR);
    lit("clr", 64'(qa), ma, 64'h00);

    // A's sin_l comes from B's sout_r; keep B full of ones.
    da = 8'h00; db = 8'hFF; sl_b = 1'b1;
    op(1'b1, MODE_LOAD);
    op(1'b1, MODE_SHR);
    lit("shr_1", 64'(qa), ma, 64'h80);
    op(1'b1, MODE_SHR);
    lit("shr_2", 64'(qa), ma, 64'hC0);
    rst = 1'b0;
    op(1'b1, MODE_SHR);
    lit("shr_rst", 64'(qa), ma, 64'hA5);
    rst = 1'b1;
    op(1'b1, MODE_SHR);
    lit("shr_4", 64'(qa), ma, 64'hD2);

    for (int i = 0; i < 200; i++) begin
      rst  = ($urandom_range(0, 31) != 0);
      da   = 8'($urandom);
      db   = 8'($urandom);
      dc   = 1'($urandom);
      sr_a = 1'($urandom);
      sl_b = 1'($urandom);
      sl_c = 1'($urandom);
      sr_c = 1'($urandom);
      op($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
    end
    rst = 1'b1;
    op(1'b0, MODE_HOLD);
    op(1'b0, MODE_HOLD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
